// File: rtl/acc_pkg.sv
// Shared types and constants for the product accumulator.
// Block lengths are 4-bit codes where 0 encodes the maximum length of 16.
package acc_pkg;

    localparam int unsigned LEN_W   = 4;
    localparam int unsigned MAX_LEN = 16;

    typedef enum logic [1:0] {
        ACC     = 2'd0,
        SEND_LO = 2'd1,
        SEND_HI = 2'd2
    } acc_state_t;

    // Index of the last beat for a length code; wraps so that code 0 yields 15.
    function automatic logic [LEN_W-1:0] last_index(input logic [LEN_W-1:0] len_code);
        return len_code - LEN_W'(1);
    endfunction

endpackage

// File: rtl/sat_add.sv
// Saturating adder: adds an 8-bit unsigned addend to an ACC_W-bit accumulator,
// clamping at all-ones and flagging when the clamp was applied.
module sat_add #(
    parameter int unsigned ACC_W = 12
) (
    input  logic [ACC_W-1:0] acc,
    input  logic [7:0]       addend,
    output logic [ACC_W-1:0] sum,
    output logic             ovf
);

    logic [ACC_W:0] full_sum;

    assign full_sum = {1'b0, acc} + {{(ACC_W - 7){1'b0}}, addend};
    assign ovf      = full_sum[ACC_W];
    assign sum      = ovf ? {ACC_W{1'b1}} : full_sum[ACC_W-1:0];

endmodule

// File: rtl/product_accumulator.sv
// Accumulates blocks of 8-bit multiplier products with saturation and emits
// each block sum as two bytes (low, then high carrying the sticky sat flag).
module product_accumulator
    import acc_pkg::*;
#(
    parameter int unsigned ACC_W = 12
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       in_prod,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [LEN_W-1:0] len,
    output logic [7:0]       out_byte,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_hi
);

    acc_state_t       state_q, state_d;
    logic [ACC_W-1:0] acc_q;
    logic [LEN_W-1:0] cnt_q;
    logic [LEN_W-1:0] len_q;
    logic             sat_q;

    logic [ACC_W-1:0] acc_sum;
    logic             acc_ovf;
    logic [LEN_W-1:0] cur_len;
    logic             accept;
    logic             last_beat;
    logic             hi_done;
    logic [6:0]       hi_bits;

    sat_add #(
        .ACC_W (ACC_W)
    ) u_sat_add (
        .acc    (acc_q),
        .addend (in_prod),
        .sum    (acc_sum),
        .ovf    (acc_ovf)
    );

    assign accept    = (state_q == ACC) && in_valid;
    // The first beat of a block uses the live length; later beats use the latched copy.
    assign cur_len   = (cnt_q == '0) ? len : len_q;
    assign last_beat = (cnt_q == last_index(cur_len));
    assign hi_done   = (state_q == SEND_HI) && out_ready;
    assign hi_bits   = 7'(acc_q >> 8);

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ACC:     if (accept && last_beat) state_d = SEND_LO;
            SEND_LO: if (out_ready) state_d = SEND_HI;
            SEND_HI: if (out_ready) state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // Outputs decoded from registers only
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_hi    = 1'b0;
        out_byte  = 8'h00;
        unique case (state_q)
            ACC: begin
                in_ready = 1'b1;
            end
            SEND_LO: begin
                out_valid = 1'b1;
                out_byte  = acc_q[7:0];
            end
            SEND_HI: begin
                out_valid = 1'b1;
                out_hi    = 1'b1;
                out_byte  = {sat_q, hi_bits};
            end
            default: begin
                in_ready = 1'b1;
            end
        endcase
    end

    // Datapath: accumulator, beat counter, latched length and sticky saturation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
            len_q <= '0;
            sat_q <= 1'b0;
        end else if (accept) begin
            if (cnt_q == '0) begin
                len_q <= len;
            end
            acc_q <= acc_sum;
            sat_q <= sat_q | acc_ovf;
            if (!last_beat) begin
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end else if (hi_done) begin
            acc_q <= '0;
            cnt_q <= '0;
            sat_q <= 1'b0;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (ACC_W=12 and ACC_W=10) share stimulus and
// are checked every cycle against a block-level sum model, plus literal byte expectations.
module tb_product_accumulator;

    localparam int W12 = 12;
    localparam int W10 = 10;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] in_prod;
    logic       in_valid;
    logic [3:0] len;
    logic       out_ready;

    logic       ir12, ov12, oh12;
    logic [7:0] ob12;
    logic       ir10, ov10, oh10;
    logic [7:0] ob10;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state per instance: 0 collecting, 1 low byte pending, 2 high byte pending
    int m_mode [2];
    int m_blen [2];
    int m_n    [2];
    int m_tot  [2];
    int m_sum  [2];
    int m_sat  [2];

    // Transferred bytes as {out_hi, out_byte}
    int log12 [$];
    int log10 [$];

    always #5 clk = ~clk;

    product_accumulator #(.ACC_W(W12)) dut12 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_ready  (ir12),
        .len       (len),
        .out_byte  (ob12),
        .out_valid (ov12),
        .out_ready (out_ready),
        .out_hi    (oh12)
    );

    product_accumulator #(.ACC_W(W10)) dut10 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_prod   (in_prod),
        .in_valid  (in_valid),
        .in_ready  (ir10),
        .len       (len),
        .out_byte  (ob10),
        .out_valid (ov10),
        .out_ready (out_ready),
        .out_hi    (oh10)
    );

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    function automatic int width_of(input int i);
        return (i == 0) ? W12 : W10;
    endfunction

    function automatic int exp_byte(input int i);
        if (m_mode[i] == 1) return m_sum[i] % 256;
        if (m_mode[i] == 2) return (m_sat[i] * 128) + (m_sum[i] / 256);
        return 0;
    endfunction

    // Model: sum of a whole block, clamped once at the end (all addends are non-negative).
    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                m_mode[i] = 0; m_blen[i] = 0; m_n[i] = 0;
                m_tot[i]  = 0; m_sum[i]  = 0; m_sat[i] = 0;
            end else begin
                case (m_mode[i])
                    0: if (in_valid) begin
                        int max_v;
                        if (m_n[i] == 0) m_blen[i] = (len == 0) ? 16 : int'(len);
                        m_tot[i] += int'(in_prod);
                        m_n[i]++;
                        if (m_n[i] == m_blen[i]) begin
                            max_v    = (1 << width_of(i)) - 1;
                            m_sat[i] = (m_tot[i] > max_v) ? 1 : 0;
                            m_sum[i] = (m_tot[i] > max_v) ? max_v : m_tot[i];
                            m_mode[i] = 1;
                        end
                    end
                    1: if (out_ready) m_mode[i] = 2;
                    default: if (out_ready) begin
                        m_mode[i] = 0; m_n[i] = 0; m_tot[i] = 0;
                    end
                endcase
            end
        end
    end

    // Per-cycle compare and transfer log
    always @(negedge clk) begin
        check("in_ready12",  ir12, (m_mode[0] == 0) ? 1 : 0);
        check("out_valid12", ov12, (m_mode[0] != 0) ? 1 : 0);
        check("out_hi12",    oh12, (m_mode[0] == 2) ? 1 : 0);
        check("out_byte12",  ob12, exp_byte(0));
        check("in_ready10",  ir10, (m_mode[1] == 0) ? 1 : 0);
        check("out_valid10", ov10, (m_mode[1] != 0) ? 1 : 0);
        check("out_hi10",    oh10, (m_mode[1] == 2) ? 1 : 0);
        check("out_byte10",  ob10, exp_byte(1));
        if (rst_n && ov12 && out_ready) log12.push_back({23'd0, oh12, ob12});
        if (rst_n && ov10 && out_ready) log10.push_back({23'd0, oh10, ob10});
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int p);
        in_valid = 1'b1;
        in_prod  = 8'(p);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_logs(input string name, input int n);
        for (int c = 0; c < 40 && (log12.size() < n || log10.size() < n); c++) tick();
        check({name, "_cnt12"}, log12.size(), n);
        check({name, "_cnt10"}, log10.size(), n);
    endtask

    task automatic expect_pair(input string name, input int lo12, input int hi12,
                               input int lo10, input int hi10);
        wait_logs(name, 2);
        if (log12.size() >= 2) begin
            check({name, "_lo12"}, log12[0], lo12);
            check({name, "_hi12"}, log12[1], hi12);
        end
        if (log10.size() >= 2) begin
            check({name, "_lo10"}, log10[0], lo10);
            check({name, "_hi10"}, log10[1], hi10);
        end
        log12.delete();
        log10.delete();
    endtask

    initial begin
        rst_n = 1'b0; in_prod = '0; in_valid = 1'b0; len = '0; out_ready = 1'b1;
        repeat (3) tick();
        check("rst_in_ready",  ir12, 1);
        check("rst_out_valid", ov12, 0);
        check("rst_out_byte",  ob12, 0);
        check("rst_out_hi",    oh12, 0);
        rst_n = 1'b1;
        tick();

        // Basic block, with a len change after the first beat that must be ignored
        len = 4'd3;
        send(15);
        len = 4'd7;
        send(200);
        send(225);
        check("basic_busy", ir12, 0);
        tick();
        tick();
        check("basic_ready_again", ir12, 1);
        expect_pair("basic", 'h0B8, 'h101, 'h0B8, 'h101);

        // Full 16-beat block: 3600 fits in 12 bits, clamps to 1023 in 10 bits
        len = 4'd0;
        for (int k = 0; k < 16; k++) send(225);
        expect_pair("full", 'h010, 'h10E, 'h0FF, 'h183);

        // Output backpressure in SEND_LO with products presented
        len = 4'd2;
        send(10);
        out_ready = 1'b0;
        send(20);
        for (int k = 0; k < 5; k++) begin
            in_valid = (k % 2 == 0);
            in_prod  = 8'd99;
            tick();
            check("bp_byte", ob12, 'h1E);
            check("bp_in_ready", ir12, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        expect_pair("bp", 'h01E, 'h100, 'h01E, 'h100);

        // Saturation in the 10-bit instance, then sat cleared on a len=1 block
        len = 4'd5;
        for (int k = 0; k < 5; k++) send(225);
        expect_pair("sat", 'h065, 'h104, 'h0FF, 'h183);
        len = 4'd1;
        send(7);
        expect_pair("len1", 'h007, 'h100, 'h007, 'h100);

        // Mid-block reset discards the partial block
        len = 4'd4;
        send(50);
        send(60);
        rst_n = 1'b0;
        tick();
        check("mid_rst_in_ready",  ir12, 1);
        check("mid_rst_out_valid", ov12, 0);
        rst_n = 1'b1;
        tick();
        len = 4'd2;
        send(3);
        send(4);
        expect_pair("post_rst", 'h007, 'h100, 'h007, 'h100);

        repeat (3) tick();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
